seq_div: RTL and testbench
==========================

// Module: seq_div
// PURPOSE
//   Sequential restoring divider: unsigned dividend / unsigned divisor -> quotient, remainder.
//   Inverse companion of the sequential multiplier. Recovers a factor from a product
//   (e.g. 143 / 11 -> 13 r0). One quotient bit per clock.
//   Feeds the same 4-digit display top: dividend/divisor on digits 1-2, quotient on digits 3-4.
// PARAMETERS
//   DW  8  dividend and quotient width
//   VW  4  divisor and remainder width (VW <= DW)
// PORTS
//   clk        in   1   system clock, rising edge
//   clr        in   1   reset; synchronous, active-low
//   start      in   1   request; sampled only in IDLE
//   dividend   in   DW  unsigned dividend; captured on accepted start
//   divisor    in   VW  unsigned divisor; captured on accepted start
//   quotient   out  DW  result; held until the next accepted start
//   remainder  out  VW  result; held until the next accepted start
//   busy       out  1   high while in RUN
//   done       out  1   one-cycle pulse when quotient/remainder become valid
//   div0       out  1   present only with SEQ_DIV_DIV0_FLAG_EN (see CONFIGURATION)
// BEHAVIOUR
//   Reset (clr==0 at a rising edge): state=IDLE; quotient=0, remainder=0, busy=0, done=0,
//     div0=0, internal regs cleared. Applies mid-RUN: operation is abandoned, no done pulse.
//   States: IDLE, RUN, DONE.
//   IDLE: start==1 at edge N -> capture operands.
//     divisor!=0: partial remainder P=0 (VW+1 bits), shift reg D=dividend, cnt=DW-1;
//       go RUN; busy=1 from edge N.
//     divisor==0: go DONE directly; quotient={DW{1'b1}}, remainder=0.
//   RUN, per edge: T={P[VW-1:0],D[DW-1]}. If T>=divisor, P=T-divisor and q-bit=1;
//     else P=T and q-bit=0. D={D[DW-2:0],q-bit}.
//     When cnt==0: quotient=D, remainder=P[VW-1:0], go DONE, busy=0. Otherwise cnt-=1.
//   DONE: done=1 for exactly one cycle, then IDLE.
//   Latency: start at edge N -> done high in the cycle after edge N+DW.
//     Divide-by-zero: done high in the cycle after edge N.
//   start during RUN or DONE is ignored (not queued). Operand changes after capture have no effect.
//   Back-to-back: start may be high in the first IDLE cycle after DONE.
//   quotient/remainder update only at RUN completion or on divide-by-zero.
//     They are not disturbed by an ignored start.
//   Arithmetic: T is VW+1 bits, compared and subtracted at VW+1 bits; remainder < divisor always.
// CONFIGURATION
//   SEQ_DIV_DIV0_FLAG_EN defined: port div0 exists.
//     div0=1 together with the divide-by-zero result; held until the next accepted start or reset.
//   Undefined: port absent. Divide-by-zero result and timing are unchanged.
// STRUCTURE
//   Package seq_div_pkg: state enum {IDLE,RUN,DONE}, default widths DW/VW,
//     localparam CNT_W=$clog2(DW).
//   Sub-module seq_div_step (combinational): inputs P, next dividend bit, divisor;
//     outputs new P and q-bit. All registers stay in seq_div.
// TESTING
//   200 / 7 -> done after 8 cycles; quotient=28, remainder=4; busy high exactly 8 cycles.
//   143 / 11 -> 13 r0; 255 / 15 -> 17 r0; 5 / 9 -> 0 r5; 255 / 1 -> 255 r0.
//   Divisor 0, dividend 77 -> done the cycle after start; quotient=255, remainder=0;
//     div0=1 when the macro is defined.
//   Start 100/3, pulse start with 9/2 at cycle 3 -> ignored; result 33 r1;
//     operand change mid-RUN has no effect.
//   clr=0 at cycle 4 of RUN -> next cycle all outputs 0, IDLE, no done.
//     Subsequent 60/4 -> 15 r0.
//   Exhaustive all 256x16 operand pairs vs reference model.
//     Includes back-to-back starts on the cycle after DONE.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned VW_DEF = 4;
  localparam int unsigned CNT_W  = $clog2(DW_DEF);

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_div_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW:0]   i_p,
  input  logic          i_bit,
  input  logic [VW-1:0] i_div,
  output logic [VW:0]   o_p,
  output logic          o_q
);

  logic [VW:0] w_t;
  logic [VW:0] w_div_ext;
  // P is always below the divisor, so its MSB never carries information.
  logic        unused_p_msb;

  assign unused_p_msb = i_p[VW];
  assign w_t          = {i_p[VW-1:0], i_bit};
  assign w_div_ext    = {1'b0, i_div};

  always_comb begin
    o_q = 1'b0;
    o_p = w_t;
    if (w_t >= w_div_ext) begin
      o_q = 1'b1;
      o_p = w_t - w_div_ext;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional div0 flag port enabled by defining SEQ_DIV_DIV0_FLAG_EN.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done
`ifdef SEQ_DIV_DIV0_FLAG_EN
  ,
  output logic          div0
`endif
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  state_e        r_state_q, r_state_d;
  logic [VW:0]   r_p_q, r_p_d;
  logic [DW-1:0] r_d_q, r_d_d;
  logic [CW-1:0] r_cnt_q, r_cnt_d;
  logic [VW-1:0] r_div_q, r_div_d;
  logic [DW-1:0] r_quot_q, r_quot_d;
  logic [VW-1:0] r_rem_q, r_rem_d;
  logic          r_div0_q, r_div0_d;

  logic [VW:0]   w_p_next;
  logic          w_q_bit;

  seq_div_step #(
    .VW (VW)
  ) u_step (
    .i_p   (r_p_q),
    .i_bit (r_d_q[DW-1]),
    .i_div (r_div_q),
    .o_p   (w_p_next),
    .o_q   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state_q <= StIdle;
      r_p_q     <= '0;
      r_d_q     <= '0;
      r_cnt_q   <= '0;
      r_div_q   <= '0;
      r_quot_q  <= '0;
      r_rem_q   <= '0;
      r_div0_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_p_q     <= r_p_d;
      r_d_q     <= r_d_d;
      r_cnt_q   <= r_cnt_d;
      r_div_q   <= r_div_d;
      r_quot_q  <= r_quot_d;
      r_rem_q   <= r_rem_d;
      r_div0_q  <= r_div0_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_p_d     = r_p_q;
    r_d_d     = r_d_q;
    r_cnt_d   = r_cnt_q;
    r_div_d   = r_div_q;
    r_quot_d  = r_quot_q;
    r_rem_d   = r_rem_q;
    r_div0_d  = r_div0_q;
    unique case (r_state_q)
      StIdle: begin
        if (start) begin
          r_div_d  = divisor;
          r_div0_d = 1'b0;
          if (divisor != '0) begin
            r_p_d     = '0;
            r_d_d     = dividend;
            r_cnt_d   = CW'(DW - 1);
            r_state_d = StRun;
          end else begin
            r_quot_d  = '1;
            r_rem_d   = '0;
            r_div0_d  = 1'b1;
            r_state_d = StDone;
          end
        end
      end
      StRun: begin
        r_p_d = w_p_next;
        r_d_d = {r_d_q[DW-2:0], w_q_bit};
        if (r_cnt_q == '0) begin
          r_quot_d  = {r_d_q[DW-2:0], w_q_bit};
          r_rem_d   = w_p_next[VW-1:0];
          r_state_d = StDone;
        end else begin
          r_cnt_d = r_cnt_q - 1'b1;
        end
      end
      StDone:  r_state_d = StIdle;
      default: r_state_d = StIdle;
    endcase
  end

  assign quotient  = r_quot_q;
  assign remainder = r_rem_q;
  assign busy      = (r_state_q == StRun);
  assign done      = (r_state_q == StDone);

`ifdef SEQ_DIV_DIV0_FLAG_EN
  assign div0 = r_div0_q;
`else
  logic unused_div0;
  assign unused_div0 = r_div0_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (DW=8, VW=4), including an exhaustive sweep.
module tb_seq_div;

  logic       clk;
  logic       clr;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
`ifdef SEQ_DIV_DIV0_FLAG_EN
  logic       div0;
`endif

  int checks = 0;
  int errors = 0;

  seq_div #(
    .DW (8),
    .VW (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef SEQ_DIV_DIV0_FLAG_EN
    ,
    .div0      (div0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and wait (bounded) for done; leaves the bench in the DONE cycle.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b, output int cyc, output int bcnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    bcnt  = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout %0d/%0d: done=%b after %0d cycles, required 1", a, b, done, cyc);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    checks += 4;
    if (quotient !== 8'd0) begin errors++; $display("FAIL reset_q: %0d, required 0", quotient); end
    if (remainder !== 4'd0) begin errors++; $display("FAIL reset_r: %0d, required 0", remainder); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b, required 0", done); end
`ifdef SEQ_DIV_DIV0_FLAG_EN
    checks++;
    if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0: %b, required 0", div0); end
`endif
    clr = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc, bcnt;
    do_div(8'd200, 4'd7, cyc, bcnt);
    checks += 4;
    if (cyc !== 8) begin errors++; $display("FAIL lat_200_7: %0d, required 8", cyc); end
    if (bcnt !== 8) begin errors++; $display("FAIL busy_200_7: %0d, required 8", bcnt); end
    if (quotient !== 8'd28) begin errors++; $display("FAIL q_200_7: %0d, required 28", quotient); end
    if (remainder !== 4'd4) begin errors++; $display("FAIL r_200_7: %0d, required 4", remainder); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: %b, required 0", done); end
  endtask

  task automatic test_vectors();
    logic [7:0] va[4] = '{8'd143, 8'd255, 8'd5, 8'd255};
    logic [3:0] vb[4] = '{4'd11, 4'd15, 4'd9, 4'd1};
    logic [7:0] vq[4] = '{8'd13, 8'd17, 8'd0, 8'd255};
    logic [3:0] vr[4] = '{4'd0, 4'd0, 4'd5, 4'd0};
    int cyc, bcnt;
    for (int i = 0; i < 4; i++) begin
      do_div(va[i], vb[i], cyc, bcnt);
      checks += 2;
      if (quotient !== vq[i]) begin
        errors++;
        $display("FAIL vec_q %0d/%0d: %0d, required %0d", va[i], vb[i], quotient, vq[i]);
      end
      if (remainder !== vr[i]) begin
        errors++;
        $display("FAIL vec_r %0d/%0d: %0d, required %0d", va[i], vb[i], remainder, vr[i]);
      end
      tick();
    end
  endtask

  task automatic test_div0();
    int cyc, bcnt;
    do_div(8'd77, 4'd0, cyc, bcnt);
    checks += 3;
    if (cyc !== 0) begin errors++; $display("FAIL div0_lat: %0d, required 0", cyc); end
    if (quotient !== 8'd255) begin errors++; $display("FAIL div0_q: %0d, required 255", quotient); end
    if (remainder !== 4'd0) begin errors++; $display("FAIL div0_r: %0d, required 0", remainder); end
`ifdef SEQ_DIV_DIV0_FLAG_EN
    checks++;
    if (div0 !== 1'b1) begin errors++; $display("FAIL div0_flag: %b, required 1", div0); end
    tick();
    tick();
    checks++;
    if (div0 !== 1'b1) begin errors++; $display("FAIL div0_hold: %b, required 1", div0); end
    do_div(8'd143, 4'd11, cyc, bcnt);
    checks++;
    if (div0 !== 1'b0) begin errors++; $display("FAIL div0_clear: %b, required 0", div0); end
`endif
    tick();
  endtask

  task automatic test_ignored_start();
    int cyc, bcnt;
    do_div(8'd255, 4'd15, cyc, bcnt);
    tick();
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd2;
    tick();
    start = 1'b0;
    checks += 2;
    if (quotient !== 8'd17) begin errors++; $display("FAIL ign_hold_q: %0d, required 17", quotient); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: %b, required 1", busy); end
    cyc = 3;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checks += 3;
    if (cyc !== 8) begin errors++; $display("FAIL ign_lat: %0d, required 8", cyc); end
    if (quotient !== 8'd33) begin errors++; $display("FAIL ign_q: %0d, required 33", quotient); end
    if (remainder !== 4'd1) begin errors++; $display("FAIL ign_r: %0d, required 1", remainder); end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ign_requeue: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcnt;
    int seen_done;
    do_div(8'd255, 4'd1, cyc, bcnt);
    tick();
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    clr = 1'b0;
    tick();
    checks += 4;
    if (quotient !== 8'd0) begin errors++; $display("FAIL rst_run_q: %0d, required 0", quotient); end
    if (remainder !== 4'd0) begin errors++; $display("FAIL rst_run_r: %0d, required 0", remainder); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_run_done: %b, required 0", done); end
    clr = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen_done++;
      tick();
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL rst_run_idle: %0d active cycles, required 0", seen_done); end
    do_div(8'd60, 4'd4, cyc, bcnt);
    checks += 2;
    if (quotient !== 8'd15) begin errors++; $display("FAIL after_rst_q: %0d, required 15", quotient); end
    if (remainder !== 4'd0) begin errors++; $display("FAIL after_rst_r: %0d, required 0", remainder); end
    tick();
  endtask

  // Every operand pair, each start issued in the first IDLE cycle after the previous DONE.
  task automatic test_back_to_back();
    int cyc, bcnt;
    logic [7:0] eq;
    logic [3:0] er;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 8'd255;
          er = 4'd0;
        end else begin
          eq = 8'(a / b);
          er = 4'(a % b);
        end
        do_div(8'(a), 4'(b), cyc, bcnt);
        checks += 3;
        if (quotient !== eq || remainder !== er) begin
          errors++;
          $display("FAIL exh %0d/%0d: %0d r%0d, required %0d r%0d", a, b, quotient, remainder, eq, er);
        end
        if (cyc !== ((b == 0) ? 0 : 8)) begin
          errors++;
          $display("FAIL exh_lat %0d/%0d: %0d", a, b, cyc);
        end
        if (bcnt !== ((b == 0) ? 0 : 8)) begin
          errors++;
          $display("FAIL exh_busy %0d/%0d: %0d", a, b, bcnt);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div0();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
